// File: rtl/arith_int_cast_pipe.sv
// Multi-lane integer width converter (extend / wrap / saturate) with a registered
// main+skid output stage and a saturating overflow-event counter.

module arith_int_cast_lane #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 32
) (
    input  logic [IN_WIDTH-1:0]  din,
    input  logic [1:0]           mode,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 ovf
);
    generate
        if (OUT_WIDTH >= IN_WIDTH) begin : g_widen
            // Even modes treat the input as signed, odd modes as unsigned.
            always_comb begin
                dout = mode[0] ? OUT_WIDTH'(din) : OUT_WIDTH'($signed(din));
                ovf  = 1'b0;
            end
        end else begin : g_narrow
            localparam int DROP = IN_WIDTH - OUT_WIDTH;
            logic [OUT_WIDTH-1:0] low;
            logic [OUT_WIDTH-1:0] smin;
            logic [OUT_WIDTH-1:0] smax;
            logic [DROP-1:0]      upper;
            logic                 fits_s;
            logic                 fits_u;
            logic                 neg;

            assign low    = din[OUT_WIDTH-1:0];
            assign upper  = din[IN_WIDTH-1:OUT_WIDTH];
            // Signed fit: every discarded bit equals the kept sign bit.
            assign fits_s = (upper == {DROP{low[OUT_WIDTH-1]}});
            assign fits_u = (upper == '0);
            assign neg    = din[IN_WIDTH-1];
            // Shift form keeps OUT_WIDTH == 1 legal (no zero-width replication).
            assign smin   = OUT_WIDTH'(1) << (OUT_WIDTH - 1);
            assign smax   = ~smin;

            always_comb begin
                case (mode)
                    2'd0: begin
                        dout = low;
                        ovf  = ~fits_s;
                    end
                    2'd1: begin
                        dout = low;
                        ovf  = ~fits_u;
                    end
                    2'd2: begin
                        dout = fits_s ? low : (neg ? smin : smax);
                        ovf  = ~fits_s;
                    end
                    default: begin
                        dout = fits_u ? low : '1;
                        ovf  = ~fits_u;
                    end
                endcase
            end
        end
    endgenerate
endmodule

module arith_int_cast_pipe #(
    parameter int IN_WIDTH    = 64,
    parameter int OUT_WIDTH   = 32,
    parameter int LANES       = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         a_valid,
    output logic                         a_ready,
    input  logic [LANES*IN_WIDTH-1:0]    a_data,
    input  logic [1:0]                   a_mode,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic [LANES*OUT_WIDTH-1:0]   result_data,
    output logic [LANES-1:0]             result_ovf,
    output logic [COUNT_WIDTH-1:0]       ovf_count,
    input  logic                         cnt_clear
);
    typedef struct packed {
        logic [LANES-1:0][OUT_WIDTH-1:0] data;
        logic [LANES-1:0]                ovf;
    } entry_t;

    logic [LANES-1:0][IN_WIDTH-1:0]  a_lanes;
    logic [LANES-1:0][OUT_WIDTH-1:0] conv_data;
    logic [LANES-1:0]                conv_ovf;
    entry_t                          conv;
    entry_t                          main_q;
    entry_t                          skid_q;
    logic                            main_full;
    logic                            skid_full;
    logic                            accept;
    logic                            consume;
    logic [COUNT_WIDTH-1:0]          cnt;

    assign a_lanes = a_data;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            arith_int_cast_lane #(
                .IN_WIDTH (IN_WIDTH),
                .OUT_WIDTH(OUT_WIDTH)
            ) u_lane (
                .din (a_lanes[i]),
                .mode(a_mode),
                .dout(conv_data[i]),
                .ovf (conv_ovf[i])
            );
        end
    endgenerate

    assign conv = {conv_data, conv_ovf};

    // a_ready depends only on stored state (and reset), never on result_ready.
    assign a_ready      = ~skid_full & ~rst;
    assign accept       = a_valid & a_ready;
    assign consume      = main_full & result_ready;

    assign result_valid = main_full;
    assign result_data  = main_q.data;
    assign result_ovf   = main_q.ovf;
    assign ovf_count    = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_full <= 1'b0;
            skid_full <= 1'b0;
            main_q    <= '0;
            skid_q    <= '0;
        end else if (consume) begin
            // skid_full implies no accept this cycle, so skid simply drains into main.
            if (skid_full) begin
                main_q    <= skid_q;
                skid_full <= 1'b0;
            end else if (accept) begin
                main_q    <= conv;
            end else begin
                main_full <= 1'b0;
            end
        end else if (accept) begin
            if (!main_full) begin
                main_q    <= conv;
                main_full <= 1'b1;
            end else begin
                skid_q    <= conv;
                skid_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            cnt <= '0;
        end else if (consume && (|main_q.ovf) && !(&cnt)) begin
            cnt <= cnt + COUNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_arith_int_cast_pipe.sv
// Randomized + directed bench for arith_int_cast_pipe against an arithmetic reference model.

module tb_arith_int_cast_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // Narrowing DUT: IN=16, OUT=8, LANES=2, COUNT_WIDTH=2
    logic        a_valid, a_ready, result_valid, result_ready, cnt_clear;
    logic [31:0] a_data;
    logic [1:0]  a_mode;
    logic [15:0] result_data;
    logic [1:0]  result_ovf;
    logic [1:0]  ovf_count;

    // Widening DUT: IN=8, OUT=16, LANES=1
    logic        w_a_valid, w_a_ready, w_result_valid, w_result_ready, w_cnt_clear;
    logic [7:0]  w_a_data;
    logic [1:0]  w_a_mode;
    logic [15:0] w_result_data;
    logic [0:0]  w_result_ovf;
    logic [15:0] w_ovf_count;

    arith_int_cast_pipe #(.IN_WIDTH(16), .OUT_WIDTH(8), .LANES(2), .COUNT_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .a_mode(a_mode), .result_valid(result_valid), .result_ready(result_ready),
        .result_data(result_data), .result_ovf(result_ovf), .ovf_count(ovf_count),
        .cnt_clear(cnt_clear)
    );

    arith_int_cast_pipe #(.IN_WIDTH(8), .OUT_WIDTH(16), .LANES(1), .COUNT_WIDTH(16)) dut_w (
        .clk(clk), .rst(rst), .a_valid(w_a_valid), .a_ready(w_a_ready), .a_data(w_a_data),
        .a_mode(w_a_mode), .result_valid(w_result_valid), .result_ready(w_result_ready),
        .result_data(w_result_data), .result_ovf(w_result_ovf), .ovf_count(w_ovf_count),
        .cnt_clear(w_cnt_clear)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference cast using plain integer arithmetic on the numeric value.
    function automatic void ref_cast(input int inw, input int outw, input longint x,
                                     input int mode, output longint y, output bit o);
        longint om, s, lo, lo_s, maxv, minv;
        om = longint'(1) << outw;
        s  = x[inw-1] ? x - (longint'(1) << inw) : x;
        o  = 1'b0;
        if (outw >= inw) begin
            y = ((mode == 0 || mode == 2) ? s : x) & (om - 1);
        end else begin
            lo   = x & (om - 1);
            lo_s = (lo >= om / 2) ? lo - om : lo;
            maxv = om / 2 - 1;
            minv = -(om / 2);
            case (mode)
                0: begin y = lo; o = (lo_s != s); end
                1: begin y = lo; o = (x >= om); end
                2: begin
                    if (s > maxv)      begin y = maxv; o = 1'b1; end
                    else if (s < minv) begin y = minv & (om - 1); o = 1'b1; end
                    else               y = lo;
                end
                default: begin
                    if (x >= om) begin y = om - 1; o = 1'b1; end
                    else         y = x;
                end
            endcase
        end
    endfunction

    function automatic logic [17:0] predict(input logic [31:0] d, input logic [1:0] m);
        logic [17:0] r;
        longint      y;
        bit          o;
        r = '0;
        for (int i = 0; i < 2; i++) begin
            ref_cast(16, 8, longint'(d[i*16 +: 16]), int'(m), y, o);
            r[i*8 +: 8] = y[7:0];
            r[16+i]     = o;
        end
        return r;
    endfunction

    // Scoreboard: queue holds {ovf, data} of everything the DUT should be storing.
    logic [17:0] q[$];
    int          mcnt  = 0;
    bit          armed = 1'b0;

    always @(negedge clk) begin
        bit hs;
        bit acc;
        if (armed) begin
            chk("a_ready", a_ready, rst ? 1'b0 : (q.size() < 2));
            chk("result_valid", result_valid, q.size() != 0);
            chk("ovf_count", ovf_count, mcnt);
            if (q.size() != 0) chk("result", {result_ovf, result_data}, q[0]);
        end
        if (rst) begin
            q.delete();
            mcnt  = 0;
            armed = 1'b1;
        end else begin
            hs  = result_ready && (q.size() != 0);
            acc = a_valid && (q.size() < 2);
            if (cnt_clear) mcnt = 0;
            else if (hs && q[0][17:16] != 2'b00 && mcnt < 3) mcnt++;
            if (hs) void'(q.pop_front());
            if (acc) q.push_back(predict(a_data, a_mode));
        end
    end

    task automatic send(input logic [31:0] d, input logic [1:0] m, input logic [15:0] ed,
                        input logic [1:0] eo, input bit clr);
        a_valid = 1'b1; a_data = d; a_mode = m; result_ready = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        chk("dir_valid", result_valid, 1'b1);
        chk("dir_data", result_data, ed);
        chk("dir_ovf", result_ovf, eo);
        cnt_clear = clr;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
    endtask

    logic [15:0] wexp[4];
    logic [15:0] edges[8];
    int          outs[$];

    initial begin
        int  idx, gaps;
        bit  saw_full, first_out, acc_now;
        a_valid = 0; a_data = 0; a_mode = 0; result_ready = 0; cnt_clear = 0;
        w_a_valid = 0; w_a_data = 0; w_a_mode = 0; w_result_ready = 1; w_cnt_clear = 0;
        wexp  = '{16'hFF80, 16'h0080, 16'hFF80, 16'h0080};
        edges = '{16'h007F, 16'h0080, 16'hFF80, 16'hFF7F, 16'h00FF, 16'h0100, 16'hFFFF, 16'h8000};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_result_data", result_data, 16'h0);
        chk("rst_result_ovf", result_ovf, 2'b00);
        chk("rst_a_ready", a_ready, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("a_ready_after_rst", a_ready, 1'b1);

        // Directed narrowing cases; lane 1 in the upper half of a_data.
        send(32'hFFF0_0180, 2'd0, 16'hF080, 2'b01, 1'b0);
        chk("cnt_after_mode0", ovf_count, 2'd1);
        send(32'hFF00_0180, 2'd2, 16'h807F, 2'b11, 1'b0);
        send(32'h00FE_0100, 2'd3, 16'hFEFF, 2'b01, 1'b0);
        send(32'h00FE_00FE, 2'd1, 16'hFEFE, 2'b00, 1'b0);
        send(32'h0180_0180, 2'd0, 16'h8080, 2'b11, 1'b0);
        send(32'h0180_0180, 2'd0, 16'h8080, 2'b11, 1'b0);
        chk("cnt_saturated", ovf_count, 2'd3);
        send(32'h0180_0180, 2'd0, 16'h8080, 2'b11, 1'b1);
        chk("cnt_clear_wins", ovf_count, 2'd0);

        // Widening: 0x80 in every mode.
        for (int m = 0; m < 4; m++) begin
            w_a_valid = 1'b1; w_a_data = 8'h80; w_a_mode = 2'(m);
            @(posedge clk); #1;
            w_a_valid = 1'b0;
            chk("widen_valid", w_result_valid, 1'b1);
            chk("widen_data", w_result_data, wexp[m]);
            chk("widen_ovf", w_result_ovf, 1'b0);
            @(posedge clk); #1;
        end

        // Stream 1..6 with a_valid held, result_ready low for cycles 2-4.
        idx = 1; gaps = 0; saw_full = 0; first_out = 0;
        a_valid = 1'b1; a_mode = 2'd1; a_data = 32'(idx);
        for (int cyc = 0; cyc < 40 && outs.size() < 6; cyc++) begin
            result_ready = !(cyc >= 2 && cyc <= 4);
            @(negedge clk);
            if (result_valid && result_ready) begin
                outs.push_back(int'(result_data[7:0]));
                first_out = 1'b1;
            end else if (first_out && result_ready) begin
                gaps++;
            end
            if (!a_ready) saw_full = 1'b1;
            acc_now = a_valid && a_ready;
            @(posedge clk); #1;
            if (acc_now) begin
                idx++;
                if (idx > 6) a_valid = 1'b0;
                else a_data = 32'(idx);
            end
        end
        a_valid = 1'b0;
        chk("stream_count", outs.size(), 6);
        for (int i = 0; i < outs.size(); i++) chk("stream_order", outs[i], i + 1);
        chk("stream_saw_full", saw_full, 1'b1);
        chk("stream_gaps", gaps, 0);

        // Randomized traffic, biased toward saturation boundaries.
        for (int n = 0; n < 600; n++) begin
            a_valid      = ($urandom_range(0, 3) != 0);
            result_ready = ($urandom_range(0, 2) != 0);
            cnt_clear    = ($urandom_range(0, 24) == 0);
            a_mode       = 2'($urandom_range(0, 3));
            for (int l = 0; l < 2; l++)
                a_data[l*16 +: 16] = ($urandom_range(0, 1) != 0) ? edges[$urandom_range(0, 7)]
                                                                 : 16'($urandom);
            @(posedge clk); #1;
        end
        a_valid = 1'b0; cnt_clear = 1'b0; result_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Fill main and skid, then reset mid-stream.
        send(32'h0180_0180, 2'd0, 16'h8080, 2'b11, 1'b0);
        result_ready = 1'b0; a_valid = 1'b1; a_mode = 2'd1; a_data = 32'h0001_0002;
        @(posedge clk); #1;
        a_data = 32'h0003_0004;
        @(posedge clk); #1;
        a_valid = 1'b0;
        chk("full_a_ready", a_ready, 1'b0);
        chk("full_valid", result_valid, 1'b1);
        rst = 1'b1; a_valid = 1'b1;
        @(posedge clk); #1;
        chk("midrst_valid", result_valid, 1'b0);
        chk("midrst_cnt", ovf_count, 2'd0);
        chk("midrst_a_ready", a_ready, 1'b0);
        @(posedge clk); #1;
        chk("midrst_a_ready_held", a_ready, 1'b0);
        chk("midrst_data", result_data, 16'h0);
        rst = 1'b0; a_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_a_ready", a_ready, 1'b1);
        send(32'h0042_0081, 2'd3, 16'h4281, 2'b00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arith_int_cast_pipe.md
# arith_int_cast_pipe

Registered, multi-lane integer width converter with selectable cast mode. It generalises the combinational index cast: sign-extend, zero-extend, wrapping truncate, and signed/unsigned saturating truncate are selected per transaction. A 2-entry skid buffer gives one result per cycle under backpressure, and a saturating counter records overflow events. It sits in the arith library between dataflow producers and consumers that use valid/ready handshakes.

## Interface
- IN_WIDTH, 64, input element width in bits (≥1)
- OUT_WIDTH, 32, output element width in bits (≥1)
- LANES, 1, independent elements per transaction (≥1)
- COUNT_WIDTH, 16, width of the overflow event counter (≥1)

One clock; reset is synchronous and active-high.
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- a_valid  input  1  input transaction valid
- a_ready  output  1  input transaction accepted when a_valid && a_ready
- a_data  input  LANES*IN_WIDTH  lane i at [i*IN_WIDTH +: IN_WIDTH]
- a_mode  input  2  cast mode, sampled with a_data: 0 signed wrap, 1 unsigned wrap, 2 signed saturate, 3 unsigned saturate
- result_valid  output  1  output transaction valid
- result_ready  input  1  output consumed when result_valid && result_ready
- result_data  output  LANES*OUT_WIDTH  lane i at [i*OUT_WIDTH +: OUT_WIDTH]
- result_ovf  output  LANES  per-lane overflow flag travelling with result_data
- ovf_count  output  COUNT_WIDTH  saturating count of output handshakes with any result_ovf bit set
- cnt_clear  input  1  synchronous clear of ovf_count

## Operation
- Per-lane conversion is computed combinationally from a_data/a_mode and captured at acceptance. Mode is not stored separately.
- OUT_WIDTH ≥ IN_WIDTH:
  - Modes 0 and 2 sign-extend; modes 1 and 3 zero-extend.
  - ovf is always 0.
- OUT_WIDTH < IN_WIDTH:
  - Mode 0: low OUT_WIDTH bits. ovf = 1 if sign-extending the result back to IN_WIDTH differs from the input.
  - Mode 1: low OUT_WIDTH bits. ovf = 1 if any discarded upper bit is 1.
  - Mode 2: input treated as signed. Above 2^(OUT_WIDTH-1)-1 gives 0b0111…1; below -2^(OUT_WIDTH-1) gives 0b1000…0; otherwise low bits. ovf = 1 when clamped.
  - Mode 3: input treated as unsigned. Above 2^OUT_WIDTH-1 gives all ones; otherwise low bits. ovf = 1 when clamped.
- Buffering: an output register (main) plus one skid register.
  - Accepted data goes to main if main is empty or being consumed this cycle; otherwise it goes to skid.
  - When main is consumed and skid is full, skid moves to main in the same cycle.
  - a_ready = !skid_full. It is registered and has no combinational path from result_ready.
  - Strict FIFO order; no transaction dropped or duplicated.
- ovf_count:
  - Increments by 1 on an output handshake with |result_ovf.
  - Holds at all ones (no wrap).
  - cnt_clear forces 0; clear wins over a same-cycle increment.

## Timing
- Latency: accepted at edge N, result_valid high from after edge N with the converted data.
- Throughput: 1 transaction/cycle with result_ready held high; skid unused.
- Backpressure:
  - result_ready low with main full: one further transaction is accepted into skid.
  - a_ready falls the cycle after skid fills.
  - a_ready rises the cycle after skid drains.
- result_data and result_ovf are held stable while result_valid && !result_ready.
- Reset (rst high at an edge), in any state including mid-stream:
  - result_valid=0, result_data=0, result_ovf=0, ovf_count=0, both buffers emptied (in-flight data discarded).
  - a_ready=0 while rst is asserted, and 1 the first cycle after deassertion.
  - a_valid is ignored during reset.

## Test plan
- IN=16, OUT=8, LANES=2, mode 0, lanes {0x0180, 0xFFF0} -> {0x80 ovf=1, 0xF0 ovf=0}; ovf_count=1 after handshake.
- Same config, mode 2, lanes {0x0180, 0xFF00} -> {0x7F, 0x80}, both ovf=1. Mode 3, lanes {0x0100, 0x00FE} -> {0xFF ovf=1, 0xFE ovf=0}. Mode 1, lane 0x00FE -> 0xFE ovf=0.
- IN=8, OUT=16, lane 0x80: mode 0 -> 0xFF80, mode 1 -> 0x0080, mode 2 -> 0xFF80, mode 3 -> 0x0080; ovf always 0.
- Stream values 1..6 with a_valid held high, result_ready low for cycles 2-4:
  - exactly two transactions are held (main + skid) and a_ready is low while skid is full;
  - output sequence is 1..6 in order, no gaps or repeats;
  - with result_ready high, one output per cycle.
- COUNT_WIDTH=2:
  - five overflowing handshakes -> ovf_count sticks at 3;
  - cnt_clear asserted in the same cycle as an overflowing handshake -> 0.
- Assert rst with both buffers full:
  - next cycle result_valid=0 and ovf_count=0, with a_ready=0 while rst is held;
  - after deassertion a_ready=1, and a new transaction emerges with 1-cycle latency.
